// File: rtl/if_stage_ctrl_if.sv
// Bundles the fetch stage's hazard-unit, instruction-memory and IF/ID signals.
// The master modport is the fetch controller; slave is the surrounding pipeline and imem.
// Purely structural: no logic, no latency.
interface if_stage_ctrl_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    // Hazard unit / branch resolution
    logic               holdPC;
    logic               holdIF_ID;
    logic               flush;
    logic [ADDR_W-1:0]  branch_target;

    // Instruction memory handshake
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;

    // IF/ID pipeline register
    logic [INSTR_W-1:0] IF_ID_Instr;
    logic [ADDR_W-1:0]  IF_ID_PC4;
    logic               IF_ID_valid;

    modport master (
        input  holdPC, holdIF_ID, flush, branch_target, imem_ready, imem_rdata,
        output imem_req, imem_addr, IF_ID_Instr, IF_ID_PC4, IF_ID_valid
    );

    modport slave (
        output holdPC, holdIF_ID, flush, branch_target, imem_ready, imem_rdata,
        input  imem_req, imem_addr, IF_ID_Instr, IF_ID_PC4, IF_ID_valid
    );
endinterface

// File: rtl/if_stage_ctrl.sv
// Fetch controller: owns PC and IF/ID, issues imem requests, obeys hazard stalls, flushes on redirect.
// Latency: instruction lands in IF/ID one edge after its imem_ready cycle; one instruction/cycle sustained.
// Backpressure: holdIF_ID parks a returned word in a one-entry skid buffer (HOLD, no request) until released.
// Optional: define STALL_CNT_EN to add the saturating 16-bit stall_cnt output.
module if_stage_ctrl #(
    parameter int                   ADDR_W    = 32,
    parameter int                   INSTR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    if_stage_ctrl_if.master         bus
`ifdef STALL_CNT_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d, pc_inc;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0]  ifid_pc4_q, ifid_pc4_d;
    logic               ifid_vld_q, ifid_vld_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0]  skid_pc4_q, skid_pc4_d;
    logic               skid_vld_q, skid_vld_d;

    // Natural wrap at 2^ADDR_W is intended.
    assign pc_inc = pc_q + ADDR_W'(4);

    assign bus.imem_req    = (state_q == REQ);
    assign bus.imem_addr   = pc_q;
    assign bus.IF_ID_Instr = ifid_instr_q;
    assign bus.IF_ID_PC4   = ifid_pc4_q;
    assign bus.IF_ID_valid = ifid_vld_q;

    // State, PC, IF/ID and skid registers; everything returns to reset values immediately on rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= '0;
            ifid_vld_q   <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc4_q   <= '0;
            skid_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_vld_q   <= ifid_vld_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            skid_vld_q   <= skid_vld_d;
        end
    end

    // Next-state and datapath: flush beats hold beats normal fetch in every state.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_vld_d   = ifid_vld_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        skid_vld_d   = skid_vld_q;

        case (state_q)
            BOOT: begin
                state_d = REQ;
            end

            REQ: begin
                if (bus.flush) begin
                    // Redirect: whatever imem returned this cycle belongs to the wrong path.
                    pc_d         = bus.branch_target;
                    ifid_instr_d = NOP_INSTR;
                    ifid_pc4_d   = '0;
                    ifid_vld_d   = 1'b0;
                end else if (bus.imem_ready) begin
                    if (bus.holdIF_ID) begin
                        // Decode is stalled but the word is already here: park it.
                        skid_instr_d = bus.imem_rdata;
                        skid_pc4_d   = pc_inc;
                        skid_vld_d   = 1'b1;
                        state_d      = HOLD;
                    end else begin
                        ifid_instr_d = bus.imem_rdata;
                        ifid_pc4_d   = pc_inc;
                        ifid_vld_d   = 1'b1;
                        if (!bus.holdPC) begin
                            pc_d = pc_inc;
                        end
                    end
                end else if (!bus.holdIF_ID) begin
                    // Memory is slow and decode wants something: hand it a bubble.
                    ifid_instr_d = NOP_INSTR;
                    ifid_pc4_d   = '0;
                    ifid_vld_d   = 1'b0;
                end
            end

            HOLD: begin
                if (bus.flush) begin
                    skid_vld_d   = 1'b0;
                    pc_d         = bus.branch_target;
                    ifid_instr_d = NOP_INSTR;
                    ifid_pc4_d   = '0;
                    ifid_vld_d   = 1'b0;
                    state_d      = REQ;
                end else if (!bus.holdIF_ID) begin
                    ifid_instr_d = skid_instr_q;
                    ifid_pc4_d   = skid_pc4_q;
                    ifid_vld_d   = skid_vld_q;
                    skid_vld_d   = 1'b0;
                    if (!bus.holdPC) begin
                        pc_d = pc_inc;
                    end
                    state_d = REQ;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

`ifdef STALL_CNT_EN
    logic req_bubble;

    assign req_bubble = (state_q == REQ) && !bus.flush && !bus.imem_ready && !bus.holdIF_ID;

    // Saturating count of decode-stall and bubble cycles; redirect cycles are not stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'h0000;
        end else if (!bus.flush && (bus.holdIF_ID || req_bubble) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Directed bench for if_stage_ctrl: two instances (default reset PC, and a near-wrap reset PC).
// Stimulus pushes the expected post-edge outputs into a queue; a monitor pops and compares after each edge.
// Async reset values are compared immediately by the stimulus process.
module tb_if_stage_ctrl;

    logic clk = 1'b0;
    logic rst_n_a;
    logic rst_n_b;

    always #5 clk = ~clk;

    if_stage_ctrl_if #(.ADDR_W(32), .INSTR_W(32)) bus_a ();
    if_stage_ctrl_if #(.ADDR_W(32), .INSTR_W(32)) bus_b ();

`ifdef STALL_CNT_EN
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;
`endif

    if_stage_ctrl #(
        .ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)
    ) dut_a (
        .clk(clk), .rst_n(rst_n_a), .bus(bus_a)
`ifdef STALL_CNT_EN
        , .stall_cnt(cnt_a)
`endif
    );

    if_stage_ctrl #(
        .ADDR_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(32'h0000_0013)
    ) dut_b (
        .clk(clk), .rst_n(rst_n_b), .bus(bus_b)
`ifdef STALL_CNT_EN
        , .stall_cnt(cnt_b)
`endif
    );

    typedef struct {
        string       name;
        bit          sel;
        logic        req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        vld;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // PC4 is only meaningful alongside a valid instruction, so it is checked only then.
    task automatic chk_out(input exp_t e);
        logic        r, v;
        logic [31:0] a, i, p;
        if (e.sel) begin
            r = bus_b.imem_req; a = bus_b.imem_addr; i = bus_b.IF_ID_Instr;
            p = bus_b.IF_ID_PC4; v = bus_b.IF_ID_valid;
        end else begin
            r = bus_a.imem_req; a = bus_a.imem_addr; i = bus_a.IF_ID_Instr;
            p = bus_a.IF_ID_PC4; v = bus_a.IF_ID_valid;
        end
        cmp({e.name, ".req"},   {31'd0, r}, {31'd0, e.req});
        cmp({e.name, ".addr"},  a, e.addr);
        cmp({e.name, ".instr"}, i, e.instr);
        cmp({e.name, ".valid"}, {31'd0, v}, {31'd0, e.vld});
        if (e.vld) cmp({e.name, ".pc4"}, p, e.pc4);
    endtask

    // Monitor: one expectation per clock edge, compared 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk_out(e);
            end
        end
    end

    task automatic drv(input logic hpc, input logic hif, input logic fl,
                       input logic [31:0] tgt, input logic rdy, input logic [31:0] rd);
        bus_a.holdPC        = hpc;
        bus_a.holdIF_ID     = hif;
        bus_a.flush         = fl;
        bus_a.branch_target = tgt;
        bus_a.imem_ready    = rdy;
        bus_a.imem_rdata    = rd;
    endtask

    // Issue one cycle: queue what must be visible after the coming edge, then move to the next negedge.
    task automatic step(input string name, input bit sel, input logic req, input logic [31:0] addr,
                        input logic [31:0] instr, input logic [31:0] pc4, input logic vld);
        exp_t e;
        e.name = name; e.sel = sel; e.req = req; e.addr = addr;
        e.instr = instr; e.pc4 = pc4; e.vld = vld;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_a(input string name);
        exp_t e;
        e.name = name; e.sel = 1'b0; e.req = 1'b0; e.addr = 32'h0;
        e.instr = 32'h0; e.pc4 = 32'h0; e.vld = 1'b0;
        chk_out(e);
        cmp({name, ".pc4"}, bus_a.IF_ID_PC4, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        drv(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        bus_b.holdPC = 1'b0; bus_b.holdIF_ID = 1'b0; bus_b.flush = 1'b0;
        bus_b.branch_target = 32'h0; bus_b.imem_ready = 1'b1; bus_b.imem_rdata = 32'h0;
        repeat (2) @(negedge clk);

        // Reset state of both instances
        chk_reset_a("rst_a");
        e.name = "rst_b"; e.sel = 1'b1; e.req = 1'b0; e.addr = 32'hFFFF_FFF8;
        e.instr = 32'h0000_0013; e.pc4 = 32'h0; e.vld = 1'b0;
        chk_out(e);
`ifdef STALL_CNT_EN
        cmp("rst_stall_cnt", {16'd0, cnt_a}, 32'd0);
`endif
        rst_n_a = 1'b1;

        // Streaming fetch with imem always ready
        drv(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2008_0001);
        step("t1_boot", 0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
        step("t1_w0",   0, 1'b1, 32'h4, 32'h2008_0001, 32'h4, 1'b1);
        drv(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2009_0002);
        step("t1_w1",   0, 1'b1, 32'h8, 32'h2009_0002, 32'h8, 1'b1);

        // Load-use stall across a ready cycle: word parked, IF/ID and PC frozen, no request in HOLD
        drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hAAAA_0003);
        step("t2_cap",  0, 1'b0, 32'h8, 32'h2009_0002, 32'h8, 1'b1);
        drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        step("t2_hold", 0, 1'b0, 32'h8, 32'h2009_0002, 32'h8, 1'b1);
`ifdef STALL_CNT_EN
        cmp("t2_stall_cnt", {16'd0, cnt_a}, 32'd2);
`endif
        drv(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_0000);
        step("t2_rel",  0, 1'b1, 32'hC, 32'hAAAA_0003, 32'hC, 1'b1);
        drv(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2000_000C);
        step("t2_next", 0, 1'b1, 32'h10, 32'h2000_000C, 32'h10, 1'b1);

        // holdPC alone: instruction registered, same PC fetched again
        drv(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_0010);
        step("hpc_only",    0, 1'b1, 32'h10, 32'h1111_0010, 32'h14, 1'b1);
        drv(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_0010);
        step("hpc_refetch", 0, 1'b1, 32'h14, 32'h1111_0010, 32'h14, 1'b1);

        // Flush while in HOLD (hold still asserted): buffer dropped, redirect to 0x40
        drv(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h2222_0014);
        step("t3_hold",       0, 1'b0, 32'h14, 32'h1111_0010, 32'h14, 1'b1);
        drv(1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'hBAD1_0000);
        step("t3_flush_hold", 0, 1'b1, 32'h40, 32'h0, 32'h0, 1'b0);
        drv(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3333_0040);
        step("t3_after",      0, 1'b1, 32'h44, 32'h3333_0040, 32'h44, 1'b1);
        // Flush together with hold in REQ: flush wins, returned data discarded
        drv(1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h4444_0044);
        step("t3_flush_req",  0, 1'b1, 32'h40, 32'h0, 32'h0, 1'b0);

        // Slow memory: three bubbles, PC stable
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hBAD2_0000);
            step($sformatf("t4_bubble%0d", i), 0, 1'b1, 32'h40, 32'h0, 32'h0, 1'b0);
        end
        drv(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h5555_0040);
        step("t4_resume",  0, 1'b1, 32'h44, 32'h5555_0040, 32'h44, 1'b1);
        // Not ready while decode holds: IF/ID keeps its instruction
        drv(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'hBAD3_0000);
        step("nordy_hold", 0, 1'b1, 32'h44, 32'h5555_0040, 32'h44, 1'b1);

        // Reset pulse in the middle of HOLD
        drv(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h6666_0044);
        step("t6_hold", 0, 1'b0, 32'h44, 32'h5555_0040, 32'h44, 1'b1);
        #2 rst_n_a = 1'b0;
        #1;
        chk_reset_a("t6_async_rst");
`ifdef STALL_CNT_EN
        cmp("t6_stall_cnt", {16'd0, cnt_a}, 32'd0);
`endif
        drv(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h7777_0000);
        @(negedge clk);
        rst_n_a = 1'b1;
        step("t6_boot", 0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
        step("t6_w0",   0, 1'b1, 32'h4, 32'h7777_0000, 32'h4, 1'b1);

        // PC wrap from a near-top reset address
        rst_n_b = 1'b1;
        bus_b.imem_rdata = 32'h0000_00B0;
        step("t5_boot", 1, 1'b1, 32'hFFFF_FFF8, 32'h0000_0013, 32'h0, 1'b0);
        step("t5_a0",   1, 1'b1, 32'hFFFF_FFFC, 32'h0000_00B0, 32'hFFFF_FFFC, 1'b1);
        bus_b.imem_rdata = 32'h0000_00B1;
        step("t5_a1",   1, 1'b1, 32'h0000_0000, 32'h0000_00B1, 32'h0000_0000, 1'b1);
        bus_b.imem_rdata = 32'h0000_00B2;
        step("t5_a2",   1, 1'b1, 32'h0000_0004, 32'h0000_00B2, 32'h0000_0004, 1'b1);

        repeat (2) @(negedge clk);
        cmp("queue_drain", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
